// File: rtl/keypad_pkg.sv
// Shared types and constants for the keypad front end of the microwave timer path.
package keypad_pkg;

    localparam int unsigned NUM_KEYS         = 10;
    localparam int unsigned MAX_DIGITS       = 3;
    localparam int unsigned DEBOUNCE_DEFAULT = 4;
    localparam int unsigned CODE_W           = 4;
    localparam int unsigned CNT_W            = 8;
    localparam int unsigned DCOUNT_W         = 2;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        DEBOUNCE = 3'd1,
        EMIT     = 3'd2,
        HOLD     = 3'd3,
        RELEASE  = 3'd4
    } state_t;

endpackage

// File: rtl/keypad_encoder_onehot_bcd_enc.sv
// Combinational key decoder: BCD code of the highest pressed key, plus
// "exactly one key" and "no key" flags.
//   keypad : raw key lines, bit k = key k
//   code   : BCD of the pressed key (meaningful only when single = 1)
//   single : exactly one key line is high
//   none   : no key line is high
module onehot_bcd_enc
    import keypad_pkg::*;
(
    input  logic [NUM_KEYS-1:0] keypad,
    output logic [CODE_W-1:0]   code,
    output logic                single,
    output logic                none
);

    logic [CODE_W-1:0] pop;

    always_comb begin
        code = '0;
        pop  = '0;
        for (int k = 0; k < int'(NUM_KEYS); k++) begin
            if (keypad[k]) begin
                code = CODE_W'(k);
            end
            pop = pop + CODE_W'(keypad[k]);
        end
        single = (pop == CODE_W'(1));
        none   = (keypad == '0);
    end

endmodule

// File: rtl/keypad_encoder.sv
// Debounces the ten-key keypad, emits one active-low load strobe with the BCD
// digit per accepted press, limits entry to three digits and blocks entry
// while enablen is high.
//   clock       : rising-edge clock
//   clear       : synchronous active-high reset
//   keypad      : raw key lines, bit k = key k
//   enablen     : active-low entry enable, sampled in EMIT only
//   entry_clr   : one-cycle pulse, zeroes digit_count
//   data        : BCD digit of the last emitted key
//   loadn       : active-low one-cycle load strobe
//   digit_count : digits emitted since clear/entry_clr, saturating at 3
//   busy        : FSM is not in IDLE
module keypad_encoder
    import keypad_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
    input  logic                clock,
    input  logic                clear,
    input  logic [NUM_KEYS-1:0] keypad,
    input  logic                enablen,
    input  logic                entry_clr,
    output logic [CODE_W-1:0]   data,
    output logic                loadn,
    output logic [DCOUNT_W-1:0] digit_count,
    output logic                busy
);

    state_t              state, state_next;
    logic [CNT_W-1:0]    cnt, cnt_next;
    logic [CODE_W-1:0]   cand, cand_next;
    logic [CODE_W-1:0]   data_next;
    logic                loadn_next;
    logic [DCOUNT_W-1:0] dcount_next;
    logic                busy_next;

    logic [CODE_W-1:0]   code;
    logic                single;
    logic                none;
    logic [CNT_W:0]      cnt_inc;
    logic                cnt_done;

    onehot_bcd_enc u_enc (
        .keypad (keypad),
        .code   (code),
        .single (single),
        .none   (none)
    );

    // One extra bit so the compare cannot wrap when DEBOUNCE_CYCLES = 255.
    assign cnt_inc  = {1'b0, cnt} + (CNT_W+1)'(1);
    assign cnt_done = (cnt_inc >= (CNT_W+1)'(DEBOUNCE_CYCLES));

    // State and output registers.
    always_ff @(posedge clock) begin
        if (clear) begin
            state       <= IDLE;
            cnt         <= '0;
            cand        <= '0;
            data        <= '0;
            loadn       <= 1'b1;
            digit_count <= '0;
            busy        <= 1'b0;
        end else begin
            state       <= state_next;
            cnt         <= cnt_next;
            cand        <= cand_next;
            data        <= data_next;
            loadn       <= loadn_next;
            digit_count <= dcount_next;
            busy        <= busy_next;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        cand_next  = cand;
        data_next  = data;
        loadn_next = 1'b1;

        case (state)
            IDLE: begin
                if (single) begin
                    cand_next  = code;
                    cnt_next   = CNT_W'(1);
                    state_next = (DEBOUNCE_CYCLES <= 1) ? EMIT : DEBOUNCE;
                end else if (!none) begin
                    state_next = HOLD;
                end
            end
            DEBOUNCE: begin
                if (none) begin
                    state_next = IDLE;
                end else if (!single) begin
                    state_next = HOLD;
                end else if (code == cand) begin
                    cnt_next = cnt_inc[CNT_W-1:0];
                    if (cnt_done) begin
                        state_next = EMIT;
                    end
                end else begin
                    // A different key took over: restart on the new one.
                    cand_next = code;
                    cnt_next  = CNT_W'(1);
                end
            end
            EMIT: begin
                if (!enablen && (digit_count < DCOUNT_W'(MAX_DIGITS))) begin
                    data_next  = cand;
                    loadn_next = 1'b0;
                end
                state_next = HOLD;
            end
            HOLD: begin
                if (none) begin
                    cnt_next   = CNT_W'(1);
                    state_next = RELEASE;
                end
            end
            RELEASE: begin
                if (!none) begin
                    state_next = HOLD;
                end else if (cnt >= CNT_W'(DEBOUNCE_CYCLES)) begin
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt_inc[CNT_W-1:0];
                    if (cnt_done) begin
                        state_next = IDLE;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        busy_next = (state_next != IDLE);

        // Count strobes one cycle after they are issued; entry_clr wins.
        dcount_next = digit_count;
        if (entry_clr) begin
            dcount_next = '0;
        end else if (!loadn && (digit_count != DCOUNT_W'(MAX_DIGITS))) begin
            dcount_next = digit_count + DCOUNT_W'(1);
        end
    end

endmodule
